skew_buffer_ctrl: RTL and testbench

- Parametrised lane-skew stage between the operand fetcher and the systolic array.
- Delays lane i by a mode-selected number of cycles, either to stagger (skew) operands into the array or to re-align (deskew) its results.
- Adds a downstream stall, an input handshake, mode latching, and a flush/drain state machine with a completion pulse.

---
 rtl/skew_buffer_ctrl.sv | 126 ++++++++++++
 tb/tb_skew_buffer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_buffer_ctrl.sv
// skew_buffer_ctrl: per-lane delay chains that skew operands into, or deskew results out of, the systolic array.
// Optional SKEW_HOLD_INVALID_EN: stage 0 follows data_in on empty cycles and outputs are not zeroed.
module skew_buffer_ctrl #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [LANES-1:0][DATA_W-1:0] data_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic [LANES-1:0][DATA_W-1:0] out_data,
  output logic [LANES-1:0]             out_valid,
  output logic                         busy,
  output logic                         drain_done
);
  localparam int CNT_W = $clog2(LANES + 1);

  // state | meaning
  // IDLE  | no latched mode; mode input drives the taps directly
  // RUN   | data in flight with mode latched in mode_q
  // DRAIN | input closed; count LANES advances until every chain is empty
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                                     state_q, state_d;
  logic                                       mode_q, mode_d;
  logic [CNT_W-1:0]                           drain_cnt_q, drain_cnt_d;
  logic                                       drain_done_q, drain_done_d;
  logic [LANES-1:0][LANES-1:0][DATA_W-1:0]    stage_val_q, stage_val_d;
  logic [LANES-1:0][LANES-1:0]                stage_vld_q, stage_vld_d;

  logic advance;
  logic accept;
  logic eff_mode;

  assign advance    = !stall;
  assign in_ready   = advance && (state_q != DRAIN);
  assign accept     = in_valid && in_ready;
  assign eff_mode   = (state_q == IDLE) ? mode : mode_q;
  assign busy       = |stage_vld_q;
  assign drain_done = drain_done_q;

  always_comb begin
    stage_val_d = stage_val_q;
    stage_vld_d = stage_vld_q;
    if (advance) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = LANES - 1; s > 0; s--) begin
          stage_val_d[l][s] = stage_val_q[l][s-1];
          stage_vld_d[l][s] = stage_vld_q[l][s-1];
        end
        stage_vld_d[l][0] = accept;
`ifdef SKEW_HOLD_INVALID_EN
        stage_val_d[l][0] = data_in[l];
`else
        stage_val_d[l][0] = accept ? data_in[l] : '0;
`endif
      end
    end
  end

  // Skew taps stage l (delay l+1); deskew taps the mirrored stage (delay LANES-l).
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      out_data[l]  = eff_mode ? stage_val_q[l][LANES-1-l] : stage_val_q[l][l];
      out_valid[l] = eff_mode ? stage_vld_q[l][LANES-1-l] : stage_vld_q[l][l];
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    drain_cnt_d  = drain_cnt_q;
    drain_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        mode_d = mode;
        if (flush)  drain_done_d = 1'b1;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          state_d     = DRAIN;
          drain_cnt_d = CNT_W'(LANES);
        end else if (advance && !busy && !accept) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (advance) begin
          if (drain_cnt_q == CNT_W'(1)) begin
            state_d      = IDLE;
            drain_done_d = 1'b1;
            drain_cnt_d  = '0;
          end else begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      drain_cnt_q  <= '0;
      drain_done_q <= 1'b0;
      stage_val_q  <= '0;
      stage_vld_q  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      drain_cnt_q  <= drain_cnt_d;
      drain_done_q <= drain_done_d;
      stage_val_q  <= stage_val_d;
      stage_vld_q  <= stage_vld_d;
    end
  end
endmodule

// File: tb/tb_skew_buffer_ctrl.sv
// Testbench for skew_buffer_ctrl: history-based reference model checked every cycle plus literal spot checks.
module tb_skew_buffer_ctrl;
  localparam int L = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst_n, mode, in_valid, stall, flush;
  logic [L-1:0][W-1:0] data_in;
  logic                in_ready, busy, drain_done;
  logic [L-1:0][W-1:0] out_data;
  logic [L-1:0]        out_valid;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  skew_buffer_ctrl #(.LANES(L), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every advancing cycle appends what entered the array (beat or bubble);
  // a lane with delay D shows the entry appended D advances ago.
  logic [L-1:0][W-1:0] h_data [0:4095];
  logic                h_vld  [0:4095];
  int   adv_n = 0;
  int   base_n = 0;
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_mode_q = 1'b0;
  logic m_done = 1'b0;

  function automatic int delay_of(input int lane, input logic md);
    return md ? (L - lane) : (lane + 1);
  endfunction

  function automatic logic hist_vld(input int idx);
    if (idx < base_n || idx >= adv_n) return 1'b0;
    return h_vld[idx];
  endfunction

  function automatic logic model_busy();
    logic b = 1'b0;
    for (int k = 1; k <= L; k++) b = b | hist_vld(adv_n - k);
    return b;
  endfunction

  always @(posedge clk) begin : model_upd
    logic acc;
    logic bz;
    if (!rst_n) begin
      base_n   = adv_n;
      m_phase  = 0;
      m_mode_q = 1'b0;
      m_cnt    = 0;
      m_done   = 1'b0;
    end else begin
      acc    = in_valid && !stall && (m_phase != 2);
      bz     = model_busy();
      m_done = 1'b0;
      case (m_phase)
        0: begin
          m_mode_q = mode;
          if (flush) m_done = 1'b1;
          if (acc) m_phase = 1;
        end
        1: begin
          if (flush) begin
            m_phase = 2;
            m_cnt   = L;
          end else if (!stall && !bz && !acc) begin
            m_phase = 0;
          end
        end
        default: begin
          if (!stall) begin
            if (m_cnt == 1) begin
              m_phase = 0;
              m_done  = 1'b1;
              m_cnt   = 0;
            end else begin
              m_cnt = m_cnt - 1;
            end
          end
        end
      endcase
      if (!stall) begin
        h_vld[adv_n]  = acc;
        h_data[adv_n] = acc ? data_in : '0;
        adv_n = adv_n + 1;
      end
    end
  end

  logic [W-1:0] obs_seq [L][32];
  int           obs_cnt [L];
  int           done_cnt = 0;

  always @(negedge clk) begin : cmp
    logic [L-1:0][W-1:0] ed;
    logic [L-1:0]        ev;
    logic                em;
    int                  idx;
    #2;
    if (chk_en) begin
      em = (m_phase == 0) ? mode : m_mode_q;
      ed = '0;
      ev = '0;
      for (int l = 0; l < L; l++) begin
        idx = adv_n - delay_of(l, em);
        if (hist_vld(idx)) begin
          ev[l] = 1'b1;
          ed[l] = h_data[idx][l];
        end
      end
      chk("in_ready", 64'(in_ready), 64'(!stall && (m_phase != 2)));
      chk("busy", 64'(busy), 64'(model_busy()));
      chk("drain_done", 64'(drain_done), 64'(m_done));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_data", 64'(out_data), 64'(ed));
      if (rst_n) begin
        if (drain_done) done_cnt++;
        if (!stall) begin
          for (int l = 0; l < L; l++) begin
            if (out_valid[l]) begin
              if (obs_cnt[l] < 32) obs_seq[l][obs_cnt[l]] = out_data[l];
              obs_cnt[l]++;
            end
          end
        end
      end
    end
  end

  function automatic logic [L-1:0][W-1:0] rep(input logic [W-1:0] b);
    logic [L-1:0][W-1:0] r;
    for (int l = 0; l < L; l++) r[l] = b;
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [L-1:0][W-1:0] d, input logic st,
                     input logic fl, input logic md);
    @(negedge clk);
    in_valid = v;
    data_in  = d;
    stall    = st;
    flush    = fl;
    mode     = md;
  endtask

  task automatic clr_obs();
    for (int l = 0; l < L; l++) obs_cnt[l] = 0;
  endtask

  logic [31:0] skew_d  [4] = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000};
  logic [3:0]  skew_v  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] dsk_d   [4] = '{32'h04000000, 32'h00030000, 32'h00000200, 32'h00000001};
  logic [3:0]  dsk_v   [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rdy_low;
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; data_in = '0;
    clr_obs();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_drain_done", 64'(drain_done), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // skew latency
    cyc(1'b1, 32'h04030201, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("skew_valid", 64'(out_valid), 64'(skew_v[k]));
      chk("skew_data", 64'(out_data), 64'(skew_d[k]));
    end
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // deskew latency; mode input dropped to 0 while running must be ignored
    cyc(1'b1, 32'h04030201, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #3;
      chk("deskew_valid", 64'(out_valid), 64'(dsk_v[k]));
      chk("deskew_data", 64'(out_data), 64'(dsk_d[k]));
    end
    cyc(1'b1, 32'h08070605, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("mode_latched_valid", 64'(out_valid), 64'(4'b1000));
    chk("mode_latched_data", 64'(out_data), 64'(32'h08000000));
    repeat (8) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // stall for three cycles after cycle 1
    clr_obs();
    cyc(1'b1, rep(8'h10), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rep(8'h11), 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cyc(1'b1, rep(8'h12), 1'b1, 1'b0, 1'b0);
      #3;
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_frozen_lane0", 64'({out_valid[0], out_data[0]}), 64'({1'b1, 8'h11}));
    end
    cyc(1'b1, rep(8'h12), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rep(8'h13), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("stall_lane3_shift", 64'({out_valid[3], out_data[3]}), 64'({1'b1, 8'h10}));
    repeat (8) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < L; l++) begin
      chk("stall_count", 64'(obs_cnt[l]), 64'(4));
      chk("stall_order", 64'({obs_seq[l][0], obs_seq[l][1], obs_seq[l][2], obs_seq[l][3]}),
          64'(32'h10111213));
    end

    // drain: flush on sixth accepted beat, in_valid kept high
    clr_obs();
    done_cnt = 0;
    for (int k = 0; k < 6; k++) cyc(1'b1, rep(W'(32'h20 + k)), 1'b0, (k == 5), 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, rep(8'h30), 1'b0, 1'b0, 1'b0);
      #3;
      chk("drain_in_ready", 64'(in_ready), 64'(0));
      chk("drain_no_early_done", 64'(drain_done), 64'(0));
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("drain_done_pulse", 64'(drain_done), 64'(1));
    chk("drain_busy_clear", 64'(busy), 64'(0));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("drain_done_single", 64'(drain_done), 64'(0));
    chk("drain_idle_ready", 64'(in_ready), 64'(1));
    chk("drain_done_count", 64'(done_cnt), 64'(1));
    for (int l = 0; l < L; l++) chk("drain_beats", 64'(obs_cnt[l]), 64'(6));

    // reset while draining with drain_cnt == 2
    done_cnt = 0;
    cyc(1'b1, rep(8'h50), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rep(8'h51), 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #3;
    chk("rst_drain_valid", 64'(out_valid), 64'(0));
    chk("rst_drain_busy", 64'(busy), 64'(0));
    chk("rst_drain_ready", 64'(in_ready), 64'(1));
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_drain_no_done", 64'(done_cnt), 64'(0));

    // idle flush, then 20 back-to-back beats
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("idle_flush_done", 64'(drain_done), 64'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("idle_flush_single", 64'(drain_done), 64'(0));
    clr_obs();
    rdy_low = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, rep(W'(32'h60 + k)), 1'b0, 1'b0, 1'b0);
      #3;
      if (!in_ready) rdy_low++;
    end
    repeat (6) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("b2b_ready_low", 64'(rdy_low), 64'(0));
    for (int l = 0; l < L; l++) chk("b2b_beats", 64'(obs_cnt[l]), 64'(20));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
